csi2_pkt_handler: RTL and testbench

- Sits directly downstream of the CSI-2 header ECC checker and consumes its decoded header (dat_type, WC, EccErr, ecc_end) together with the same 32-bit lane-merged word stream.
- Short packets (FS/FE/LS/LE) become sync pulses.
- Long-packet payload is stripped of its header and CRC and forwarded as byte-enabled 32-bit words; the payload CRC-16 is checked.
- Packets with uncorrectable header errors, or truncated by LP entry, are discarded and flagged.

---
 rtl/csi2_pkt_handler.sv | 236 +++++++++++++++++++++++
 tb/tb_csi2_pkt_handler.sv | 294 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/csi2_pkt_handler.sv
// CSI-2 packet handler: turns decoded headers into sync pulses, strips long-packet payload
// into byte-enabled words and checks the payload CRC-16.
module csi2_pkt_handler #(
    parameter bit CRC_EN = 1'b1
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        lp_in,
    input  logic [31:0] mipi_dat,
    input  logic        dat_vld,
    input  logic        ecc_end,
    input  logic [5:0]  dat_type,
    input  logic [15:0] WC,
    input  logic        EccErr,
    output logic        fs,
    output logic        fe,
    output logic        ls,
    output logic        le,
    output logic [15:0] frame_num,
    output logic [31:0] pix_dat,
    output logic [3:0]  pix_be,
    output logic        pix_vld,
    output logic        pix_sol,
    output logic        pix_eol,
    output logic [5:0]  pix_type,
    output logic        crc_err,
    output logic        ecc_drop,
    output logic        trunc_err,
    output logic        busy
);

    typedef enum logic [1:0] {StIdle, StPayload, StCrc, StDrop} state_e;

    state_e      state_q, state_d;
    logic [15:0] rem_q, rem_d;
    logic [15:0] crc_q, crc_d;
    logic [7:0]  crc_lo_q, crc_lo_d;
    logic        crc_half_q, crc_half_d;
    logic        first_q, first_d;

    logic        fs_d, fe_d, ls_d, le_d, vld_d, sol_d, eol_d;
    logic        crc_err_d, ecc_drop_d, trunc_err_d;
    logic [15:0] frame_d;
    logic [31:0] dat_d;
    logic [3:0]  be_d;
    logic [5:0]  type_d;

    // Reflected CRC-16 (poly 0x1021 -> 0x8408), one byte LSB first.
    function automatic logic [15:0] crc_byte(input logic [15:0] crc, input logic [7:0] b);
        logic [15:0] c;
        c = crc ^ {8'h00, b};
        for (int i = 0; i < 8; i++) begin
            c = c[0] ? ((c >> 1) ^ 16'h8408) : (c >> 1);
        end
        return c;
    endfunction

    state_e      cur_state;
    logic [15:0] cur_rem, cur_crc, crc_f, rx;
    logic        cur_half, cur_first, done;
    logic [2:0]  n;

    always_comb begin
        state_d     = state_q;
        rem_d       = rem_q;
        crc_d       = crc_q;
        crc_lo_d    = crc_lo_q;
        crc_half_d  = crc_half_q;
        first_d     = first_q;
        fs_d        = 1'b0;
        fe_d        = 1'b0;
        ls_d        = 1'b0;
        le_d        = 1'b0;
        vld_d       = 1'b0;
        sol_d       = 1'b0;
        eol_d       = 1'b0;
        crc_err_d   = 1'b0;
        ecc_drop_d  = 1'b0;
        trunc_err_d = 1'b0;
        frame_d     = frame_num;
        dat_d       = pix_dat;
        be_d        = pix_be;
        type_d      = pix_type;
        cur_state   = state_q;
        cur_rem     = rem_q;
        cur_crc     = crc_q;
        cur_half    = crc_half_q;
        cur_first   = first_q;
        crc_f       = crc_q;
        rx          = 16'h0000;
        done        = 1'b0;
        n           = 3'd0;

        if (lp_in) begin
            if (state_q == StPayload || state_q == StCrc) begin
                trunc_err_d = 1'b1;
                crc_d       = 16'hFFFF;
                crc_half_d  = 1'b0;
            end
            state_d = StIdle;
        end else begin
            if (state_q == StIdle && ecc_end) begin
                if (EccErr) begin
                    ecc_drop_d = 1'b1;
                    state_d    = StDrop;
                end else if (dat_type < 6'h10) begin
                    case (dat_type)
                        6'h00: begin
                            fs_d    = 1'b1;
                            frame_d = WC;
                        end
                        6'h01:   fe_d = 1'b1;
                        6'h02:   ls_d = 1'b1;
                        6'h03:   le_d = 1'b1;
                        default: ;
                    endcase
                end else begin
                    // The word sharing the ecc_end cycle belongs to the new packet.
                    type_d     = dat_type;
                    cur_state  = (WC == 16'd0) ? StCrc : StPayload;
                    cur_rem    = WC;
                    cur_crc    = 16'hFFFF;
                    cur_half   = 1'b0;
                    cur_first  = 1'b1;
                    state_d    = cur_state;
                    rem_d      = WC;
                    crc_d      = 16'hFFFF;
                    crc_half_d = 1'b0;
                    first_d    = 1'b1;
                end
            end

            crc_f = cur_crc;
            if (dat_vld && cur_state == StPayload) begin
                n = (cur_rem >= 16'd4) ? 3'd4 : cur_rem[2:0];
                for (int i = 0; i < 4; i++) begin
                    if (3'(i) < n) crc_f = crc_byte(crc_f, mipi_dat[8*i +: 8]);
                end
                vld_d   = 1'b1;
                dat_d   = mipi_dat;
                sol_d   = cur_first;
                first_d = 1'b0;
                rem_d   = cur_rem - 16'(n);
                crc_d   = crc_f;
                case (n)
                    3'd1:    be_d = 4'b0001;
                    3'd2:    be_d = 4'b0011;
                    3'd3:    be_d = 4'b0111;
                    default: be_d = 4'b1111;
                endcase
                if (cur_rem == 16'(n)) begin
                    eol_d = 1'b1;
                    // Unused tail bytes of the last payload word carry the CRC, LSB first.
                    case (n)
                        3'd1: begin
                            rx   = mipi_dat[23:8];
                            done = 1'b1;
                        end
                        3'd2: begin
                            rx   = mipi_dat[31:16];
                            done = 1'b1;
                        end
                        3'd3: begin
                            crc_lo_d   = mipi_dat[31:24];
                            crc_half_d = 1'b1;
                            state_d    = StCrc;
                        end
                        default: begin
                            crc_half_d = 1'b0;
                            state_d    = StCrc;
                        end
                    endcase
                end
            end else if (dat_vld && cur_state == StCrc) begin
                rx   = cur_half ? {mipi_dat[7:0], crc_lo_q} : mipi_dat[15:0];
                done = 1'b1;
            end

            if (done) begin
                crc_err_d  = CRC_EN && (rx != crc_f);
                crc_d      = 16'hFFFF;
                crc_half_d = 1'b0;
                state_d    = StIdle;
            end
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q    <= StIdle;
            rem_q      <= 16'd0;
            crc_q      <= 16'hFFFF;
            crc_lo_q   <= 8'h00;
            crc_half_q <= 1'b0;
            first_q    <= 1'b0;
            fs         <= 1'b0;
            fe         <= 1'b0;
            ls         <= 1'b0;
            le         <= 1'b0;
            frame_num  <= 16'd0;
            pix_dat    <= 32'd0;
            pix_be     <= 4'd0;
            pix_vld    <= 1'b0;
            pix_sol    <= 1'b0;
            pix_eol    <= 1'b0;
            pix_type   <= 6'd0;
            crc_err    <= 1'b0;
            ecc_drop   <= 1'b0;
            trunc_err  <= 1'b0;
        end else begin
            state_q    <= state_d;
            rem_q      <= rem_d;
            crc_q      <= crc_d;
            crc_lo_q   <= crc_lo_d;
            crc_half_q <= crc_half_d;
            first_q    <= first_d;
            fs         <= fs_d;
            fe         <= fe_d;
            ls         <= ls_d;
            le         <= le_d;
            frame_num  <= frame_d;
            pix_dat    <= dat_d;
            pix_be     <= be_d;
            pix_vld    <= vld_d;
            pix_sol    <= sol_d;
            pix_eol    <= eol_d;
            pix_type   <= type_d;
            crc_err    <= crc_err_d;
            ecc_drop   <= ecc_drop_d;
            trunc_err  <= trunc_err_d;
        end
    end

    assign busy = (state_q != StIdle);

endmodule

// File: tb/tb_csi2_pkt_handler.sv
// Bench for csi2_pkt_handler: packet-level expectations derived from byte streams, checked
// every cycle by one compare process, plus directed and randomized packets.
module tb_csi2_pkt_handler;

    typedef logic [7:0] bq_t[$];

    logic        clk = 1'b0;
    logic        reset;
    logic        lp_in, dat_vld, ecc_end, EccErr;
    logic [31:0] mipi_dat;
    logic [5:0]  dat_type;
    logic [15:0] WC;
    logic        fs, fe, ls, le, pix_vld, pix_sol, pix_eol, crc_err, ecc_drop, trunc_err, busy;
    logic [15:0] frame_num;
    logic [31:0] pix_dat;
    logic [3:0]  pix_be;
    logic [5:0]  pix_type;

    csi2_pkt_handler dut (
        .clk(clk), .reset(reset), .lp_in(lp_in), .mipi_dat(mipi_dat), .dat_vld(dat_vld),
        .ecc_end(ecc_end), .dat_type(dat_type), .WC(WC), .EccErr(EccErr),
        .fs(fs), .fe(fe), .ls(ls), .le(le), .frame_num(frame_num), .pix_dat(pix_dat),
        .pix_be(pix_be), .pix_vld(pix_vld), .pix_sol(pix_sol), .pix_eol(pix_eol),
        .pix_type(pix_type), .crc_err(crc_err), .ecc_drop(ecc_drop), .trunc_err(trunc_err),
        .busy(busy)
    );

    always #5 clk = ~clk;

    int n_chk = 0;
    int n_pass = 0;
    int pix_cnt = 0;
    int crc_cnt = 0;
    bit chk_en = 1'b0;

    // Expected outputs after the next active edge.
    logic        e_fs, e_fe, e_ls, e_le, e_vld, e_sol, e_eol, e_crc, e_drop, e_trunc, e_busy;
    logic [15:0] e_frame;
    logic [31:0] e_dat;
    logic [3:0]  e_be;
    logic [5:0]  e_type;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    endtask

    always @(posedge clk) begin
        #1;
        if (chk_en) begin
            chk("fs", 32'(fs), 32'(e_fs));
            chk("fe", 32'(fe), 32'(e_fe));
            chk("ls", 32'(ls), 32'(e_ls));
            chk("le", 32'(le), 32'(e_le));
            chk("frame_num", 32'(frame_num), 32'(e_frame));
            chk("pix_vld", 32'(pix_vld), 32'(e_vld));
            chk("crc_err", 32'(crc_err), 32'(e_crc));
            chk("ecc_drop", 32'(ecc_drop), 32'(e_drop));
            chk("trunc_err", 32'(trunc_err), 32'(e_trunc));
            chk("busy", 32'(busy), 32'(e_busy));
            if (e_vld) begin
                chk("pix_dat", pix_dat, e_dat);
                chk("pix_be", 32'(pix_be), 32'(e_be));
                chk("pix_sol", 32'(pix_sol), 32'(e_sol));
                chk("pix_eol", 32'(pix_eol), 32'(e_eol));
                chk("pix_type", 32'(pix_type), 32'(e_type));
            end
            if (pix_vld) pix_cnt++;
            if (crc_err) crc_cnt++;
        end
    end

    // Bit-serial reflected CRC-16/0x1021, init FFFF, no final XOR.
    function automatic logic [15:0] crc_model(input bq_t bytes);
        logic [15:0] c;
        logic        fb;
        c = 16'hFFFF;
        foreach (bytes[i]) begin
            for (int b = 0; b < 8; b++) begin
                fb = c[0] ^ bytes[i][b];
                c  = c >> 1;
                if (fb) c = c ^ 16'h8408;
            end
        end
        return c;
    endfunction

    task automatic clr();
        lp_in    = 1'b0;
        dat_vld  = 1'b0;
        ecc_end  = 1'b0;
        EccErr   = 1'($urandom);
        mipi_dat = $urandom;
        dat_type = 6'($urandom);
        WC       = 16'($urandom);
        {e_fs, e_fe, e_ls, e_le, e_vld, e_sol, e_eol, e_crc, e_drop, e_trunc} = '0;
    endtask

    task automatic tick();
        @(posedge clk);
        #2;
    endtask

    task automatic check_zero(input string name);
        chk({name, "_flags"}, 32'({fs, fe, ls, le, crc_err, ecc_drop, trunc_err, pix_vld,
                                  pix_sol, pix_eol, busy}), 32'd0);
        chk({name, "_frame"}, 32'(frame_num), 32'd0);
        chk({name, "_dat"}, pix_dat, 32'd0);
        chk({name, "_be_type"}, 32'({pix_be, pix_type}), 32'd0);
    endtask

    task automatic send_short(input logic [5:0] t, input logic [15:0] wc);
        clr(); dat_vld = 1'b1; tick();
        clr();
        dat_vld = 1'($urandom);
        ecc_end = 1'b1; dat_type = t; WC = wc; EccErr = 1'b0;
        case (t)
            6'h00: begin e_fs = 1'b1; e_frame = wc; end
            6'h01: e_fe = 1'b1;
            6'h02: e_ls = 1'b1;
            6'h03: e_le = 1'b1;
            default: ;
        endcase
        tick();
    endtask

    task automatic send_drop(input logic [5:0] t, input int nwords);
        clr(); dat_vld = 1'b1; tick();
        clr(); dat_vld = 1'b1; ecc_end = 1'b1; dat_type = t; EccErr = 1'b1;
        e_drop = 1'b1; e_busy = 1'b1; tick();
        for (int k = 0; k < nwords; k++) begin
            clr(); dat_vld = 1'b1; ecc_end = (k == 1); dat_type = 6'h00; EccErr = 1'b0;
            tick();
        end
        clr(); lp_in = 1'b1; e_busy = 1'b0; tick();
    endtask

    task automatic send_long(input logic [5:0] t, input bq_t pay, input logic [15:0] rxcrc,
                             input int gap, input int trunc_at);
        bq_t         stream;
        int          wc, nw, cw, npix, nb;
        logic [15:0] calc;
        logic [4:0]  m;
        wc     = pay.size();
        stream = pay;
        stream.push_back(rxcrc[7:0]);
        stream.push_back(rxcrc[15:8]);
        while (stream.size() % 4 != 0) stream.push_back(8'($urandom));
        nw   = stream.size() / 4;
        cw   = (wc + 1) / 4;
        npix = (wc + 3) / 4;
        calc = crc_model(pay);
        clr(); dat_vld = 1'b1; tick();
        for (int w = 0; w < nw; w++) begin
            if (w > 0) begin
                for (int g = 0; g < gap; g++) begin
                    clr(); ecc_end = 1'($urandom); tick();
                end
            end
            if (w == trunc_at) begin
                clr(); lp_in = 1'b1; e_trunc = 1'b1; e_busy = 1'b0; tick();
                clr(); lp_in = 1'b1; tick();
                return;
            end
            clr();
            dat_vld  = 1'b1;
            mipi_dat = {stream[4*w+3], stream[4*w+2], stream[4*w+1], stream[4*w]};
            if (w == 0) begin
                ecc_end = 1'b1; dat_type = t; WC = 16'(wc); EccErr = 1'b0;
            end
            if (w < npix) begin
                nb    = (wc - 4 * w >= 4) ? 4 : wc - 4 * w;
                m     = (5'd1 << nb) - 5'd1;
                e_vld = 1'b1; e_dat = mipi_dat; e_be = m[3:0];
                e_sol = (w == 0); e_eol = (w == npix - 1); e_type = t;
            end
            if (w == cw) begin
                e_crc  = (calc != rxcrc);
                e_busy = 1'b0;
            end else begin
                e_busy = 1'b1;
            end
            tick();
        end
        clr(); lp_in = 1'b1; tick();
    endtask

    function automatic bq_t rand_bytes(input int len);
        bq_t q;
        for (int i = 0; i < len; i++) q.push_back(8'($urandom));
        return q;
    endfunction

    initial begin
        bq_t         spec, pay;
        int          p0, c0, wc, cw, tr, r;
        logic [15:0] calc, rxc;
        spec = '{8'hFF, 8'h00, 8'h00, 8'h02, 8'hB9, 8'hDC, 8'hF3, 8'h72, 8'hBB, 8'hD4, 8'hB8,
                 8'h5A, 8'hC8, 8'h75, 8'hC2, 8'h7C, 8'h81, 8'hF8, 8'h05, 8'hDF, 8'hFF, 8'h00,
                 8'h00, 8'h01};
        reset = 1'b1;
        clr();
        e_busy  = 1'b0;
        e_frame = 16'd0;
        repeat (2) @(posedge clk);
        #2;
        check_zero("reset");
        reset  = 1'b0;
        chk_en = 1'b1;

        chk("crc_model_vec", 32'(crc_model(spec)), 32'h00F0);
        chk("crc_model_empty", 32'(crc_model(pay)), 32'hFFFF);

        send_short(6'h00, 16'h0007);
        send_short(6'h02, 16'h1234);
        send_short(6'h03, 16'h0001);
        send_short(6'h01, 16'h0002);
        send_short(6'h05, 16'h0003);
        chk("frame_num_lit", 32'(frame_num), 32'h0007);

        p0 = pix_cnt; c0 = crc_cnt;
        send_long(6'h2A, spec, 16'h00F0, 0, -1);
        chk("spec_pix_words", pix_cnt - p0, 6);
        chk("spec_crc_ok", crc_cnt - c0, 0);
        c0 = crc_cnt;
        send_long(6'h2A, spec, 16'h00F1, 0, -1);
        chk("spec_crc_bad", crc_cnt - c0, 1);

        pay = rand_bytes(5);
        p0 = pix_cnt; c0 = crc_cnt;
        send_long(6'h24, pay, crc_model(pay), 2, -1);
        chk("wc5_pix_words", pix_cnt - p0, 2);
        chk("wc5_crc_ok", crc_cnt - c0, 0);

        send_drop(6'h2A, 3);

        p0 = pix_cnt;
        send_long(6'h2A, spec, 16'h00F0, 0, 2);
        chk("trunc_pix_words", pix_cnt - p0, 2);
        send_long(6'h2B, rand_bytes(9), 16'h0000, 1, -1);
        pay = rand_bytes(12);
        send_long(6'h2B, pay, crc_model(pay), 0, -1);

        pay.delete();
        p0 = pix_cnt; c0 = crc_cnt;
        send_long(6'h12, pay, 16'hFFFF, 0, -1);
        chk("wc0_pix_words", pix_cnt - p0, 0);
        chk("wc0_crc_ok", crc_cnt - c0, 0);

        // Reset in the middle of a payload.
        clr(); dat_vld = 1'b1; tick();
        clr(); dat_vld = 1'b1; ecc_end = 1'b1; dat_type = 6'h2A; WC = 16'd24; EccErr = 1'b0;
        e_vld = 1'b1; e_dat = mipi_dat; e_be = 4'hF; e_sol = 1'b1; e_eol = 1'b0;
        e_type = 6'h2A; e_busy = 1'b1;
        tick();
        chk_en = 1'b0;
        #3 reset = 1'b1;
        #1 check_zero("reset_mid");
        @(posedge clk);
        #2 reset = 1'b0;
        e_busy = 1'b0; e_frame = 16'd0;
        clr();
        chk_en = 1'b1;
        for (int k = 0; k < 3; k++) begin
            clr(); dat_vld = 1'b1; tick();
        end

        for (int it = 0; it < 150; it++) begin
            r = $urandom_range(0, 9);
            if (r < 2) begin
                send_short(6'($urandom_range(0, 15)), 16'($urandom));
            end else if (r == 2) begin
                send_drop(6'($urandom_range(16, 63)), $urandom_range(0, 4));
            end else begin
                wc   = $urandom_range(0, 40);
                pay  = rand_bytes(wc);
                calc = crc_model(pay);
                rxc  = ($urandom_range(0, 3) == 0) ? calc ^ (16'h1 << $urandom_range(0, 15))
                                                   : calc;
                cw   = (wc + 1) / 4;
                tr   = (cw >= 1 && $urandom_range(0, 5) == 0) ? $urandom_range(1, cw) : -1;
                send_long(6'($urandom_range(16, 63)), pay, rxc, $urandom_range(0, 2), tr);
            end
            if ($urandom_range(0, 3) == 0) begin
                clr(); tick();
            end
        end

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
